// File: rtl/lcd_timing_pkg.sv
// Shared LCD panel timing constants and tracker state encoding.
// The data-enable generator and the pixel tracker both import this package,
// so the panel geometry is defined in exactly one place.
package lcd_timing_pkg;

    localparam int H_ACTIVE   = 479;  // DE-high clocks per active line
    localparam int V_ACTIVE   = 272;  // active lines per frame
    localparam int VBLANK_MIN = 526;  // shortest DE-low run taken as vertical blank
    localparam int XW         = 10;   // pixel_x width
    localparam int YW         = 9;    // pixel_y width
    localparam int RUN_W      = 10;   // DE-low run counter width (saturates at 1023)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        ACTIVE = 2'd2,
        HBLANK = 2'd3
    } track_state_e;

endpackage

// File: rtl/de_edge_runlen.sv
// DE edge detector and run-length counters.
//   Clk, Rst_n : pixel clock / async active-low reset
//   clr        : synchronous clear of the delayed DE and both counters
//   DE_in      : data-enable strobe
//   rise, fall : combinational DE edges relative to the registered DE
//   low_run    : DE-low clocks seen since the last rise, saturating
//   high_run   : DE-high clocks in the current/last high run (1 on the rise
//                sample), saturating
module de_edge_runlen
    import lcd_timing_pkg::*;
#(
    parameter int XW = lcd_timing_pkg::XW
)(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             DE_in,
    output logic             rise,
    output logic             fall,
    output logic [RUN_W-1:0] low_run,
    output logic [XW-1:0]    high_run
);

    logic             de_q,       de_d;
    logic [RUN_W-1:0] low_run_q,  low_run_d;
    logic [XW-1:0]    high_run_q, high_run_d;

    always_comb begin
        de_d       = DE_in;
        low_run_d  = low_run_q;
        high_run_d = high_run_q;
        rise       = DE_in & ~de_q;
        fall       = ~DE_in & de_q;

        if (clr) begin
            de_d       = 1'b0;
            low_run_d  = '0;
            high_run_d = '0;
        end else if (rise) begin
            low_run_d  = '0;
            high_run_d = XW'(1);
        end else if (DE_in) begin
            if (!(&high_run_q)) high_run_d = high_run_q + XW'(1);
        end else begin
            if (!(&low_run_q)) low_run_d = low_run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            de_q       <= 1'b0;
            low_run_q  <= '0;
            high_run_q <= '0;
        end else begin
            de_q       <= de_d;
            low_run_q  <= low_run_d;
            high_run_q <= high_run_d;
        end
    end

    assign low_run  = low_run_q;
    assign high_run = high_run_q;

endmodule

// File: rtl/de_pixel_tracker.sv
// Recovers pixel coordinates from the panel DE strobe.
//   Clk, Rst_n   : pixel clock / async active-low reset
//   de_en        : tracker enable, low clears everything back to IDLE
//   DE_in        : data-enable strobe from the timing generator
//   pixel_valid  : pixel_x/pixel_y name an active pixel
//   pixel_x/y    : column / row of the current pixel
//   line_start   : pulse with the first pixel of every line
//   frame_start  : pulse with pixel (0,0)
//   locked       : frame alignment established by a vertical blank
//   line_len_err : pulse when a DE-high run is not H_ACTIVE long
//   frame_err    : pulse on a wrong line count or a line overflow
// All outputs are registered: they reflect the DE_in sample one clock earlier.
//
// state  | meaning
// IDLE   | disabled, outputs cleared
// SEEK   | unlocked, waiting for a rise that follows a vertical blank
// ACTIVE | inside a DE-high run, stepping pixel_x
// HBLANK | locked, DE low between lines
module de_pixel_tracker
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE   = lcd_timing_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = lcd_timing_pkg::V_ACTIVE,
    parameter int VBLANK_MIN = lcd_timing_pkg::VBLANK_MIN,
    parameter int XW         = lcd_timing_pkg::XW,
    parameter int YW         = lcd_timing_pkg::YW
)(
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          de_en,
    input  logic          DE_in,
    output logic          pixel_valid,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          locked,
    output logic          line_len_err,
    output logic          frame_err
);

    localparam logic [XW-1:0]    H_FULL = XW'(H_ACTIVE);
    localparam logic [XW-1:0]    X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]    Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [RUN_W-1:0] VB_MIN = RUN_W'(VBLANK_MIN);

    logic             rise, fall;
    logic [RUN_W-1:0] low_run;
    logic [XW-1:0]    high_run;

    track_state_e  state_q, state_d;
    logic          valid_q, valid_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic          locked_q, locked_d;
    logic          lle_q, lle_d;
    logic          fe_q, fe_d;

    de_edge_runlen #(.XW(XW)) u_runlen (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .clr      (~de_en),
        .DE_in    (DE_in),
        .rise     (rise),
        .fall     (fall),
        .low_run  (low_run),
        .high_run (high_run)
    );

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        lle_d    = 1'b0;
        fe_d     = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        locked_d = locked_q;

        if (!de_en) begin
            state_d  = IDLE;
            x_d      = '0;
            y_d      = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = SEEK;
                SEEK: begin
                    if (rise && low_run >= VB_MIN) begin
                        locked_d = 1'b1;
                        fs_d     = 1'b1;
                        ls_d     = 1'b1;
                        valid_d  = 1'b1;
                        x_d      = '0;
                        y_d      = '0;
                        state_d  = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (fall) begin
                        lle_d   = (high_run != H_FULL);
                        state_d = HBLANK;
                    end else begin
                        valid_d = 1'b1;
                        // Overlong line: flag once at the first extra clock, park at the last column.
                        lle_d   = (high_run == H_FULL);
                        if (x_q != X_LAST) x_d = x_q + XW'(1);
                    end
                end
                HBLANK: begin
                    if (rise) begin
                        if (low_run >= VB_MIN) begin
                            // pixel_y still holds the last row index of the frame that just ended.
                            fe_d    = (y_q != Y_LAST);
                            fs_d    = 1'b1;
                            ls_d    = 1'b1;
                            valid_d = 1'b1;
                            x_d     = '0;
                            y_d     = '0;
                            state_d = ACTIVE;
                        end else if (y_q == Y_LAST) begin
                            // One line too many: alignment is lost, wait for the next blank.
                            fe_d     = 1'b1;
                            locked_d = 1'b0;
                            state_d  = SEEK;
                        end else begin
                            ls_d    = 1'b1;
                            valid_d = 1'b1;
                            x_d     = '0;
                            y_d     = y_q + YW'(1);
                            state_d = ACTIVE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            locked_q <= 1'b0;
            lle_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
            locked_q <= locked_d;
            lle_q    <= lle_d;
            fe_q     <= fe_d;
        end
    end

    assign pixel_valid  = valid_q;
    assign pixel_x      = x_q;
    assign pixel_y      = y_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign locked       = locked_q;
    assign line_len_err = lle_q;
    assign frame_err    = fe_q;

endmodule

// File: tb/tb_de_pixel_tracker.sv
// Bench for de_pixel_tracker. The frame height is shortened to 16 lines so
// multi-frame scenarios fit a short run; line width and blank threshold keep
// their panel values.
module tb_de_pixel_tracker;
    import lcd_timing_pkg::*;

    localparam int TB_H  = 479;
    localparam int TB_V  = 16;
    localparam int TB_VB = 526;

    logic       Clk, Rst_n, de_en, DE_in;
    logic       pixel_valid, line_start, frame_start, locked, line_len_err, frame_err;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;

    de_pixel_tracker #(.H_ACTIVE(TB_H), .V_ACTIVE(TB_V), .VBLANK_MIN(TB_VB)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .de_en(de_en), .DE_in(DE_in),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start), .locked(locked),
        .line_len_err(line_len_err), .frame_err(frame_err)
    );

    always #5 Clk = ~Clk;

    int checks, errors;

    logic [24:0] obs_v, exp_v;
    assign obs_v = {pixel_valid, pixel_x, pixel_y, line_start, frame_start, locked, line_len_err, frame_err};

    // Reference model: run lengths, lock flag and current coordinates as plain integers.
    int  m_low, m_high, m_x, m_y;
    bit  m_prev, m_locked, m_armed;
    bit  e_valid, e_ls, e_fs, e_lle, e_fe;

    int cnt_valid, cnt_ls, cnt_fs, cnt_lle, cnt_fe, cnt_fefs, max_x, max_y, last_ls_y, last_fs_y;

    bit seq[$];

    function automatic void add_run(bit v, int n);
        for (int i = 0; i < n; i++) seq.push_back(v);
    endfunction

    function automatic void model_reset();
        m_low = 0; m_high = 0; m_x = 0; m_y = 0;
        m_prev = 0; m_locked = 0; m_armed = 0;
        exp_v = '0;
    endfunction

    function automatic void clear_tally();
        cnt_valid = 0; cnt_ls = 0; cnt_fs = 0; cnt_lle = 0; cnt_fe = 0; cnt_fefs = 0;
        max_x = 0; max_y = 0; last_ls_y = -1; last_fs_y = -1;
    endfunction

    function automatic void model_step(bit de, bit en);
        bit r, f;
        e_valid = 0; e_ls = 0; e_fs = 0; e_lle = 0; e_fe = 0;
        if (!en) begin
            m_low = 0; m_high = 0; m_x = 0; m_y = 0;
            m_prev = 0; m_locked = 0; m_armed = 0;
        end else begin
            r = de && !m_prev;
            f = !de && m_prev;
            if (!m_armed) begin
                m_armed = 1;
            end else if (!m_locked) begin
                if (r && m_low >= TB_VB) begin
                    m_locked = 1; e_fs = 1; e_ls = 1; e_valid = 1; m_x = 0; m_y = 0;
                end
            end else if (r) begin
                if (m_low >= TB_VB) begin
                    e_fe = (m_y + 1 != TB_V);
                    e_fs = 1; e_ls = 1; e_valid = 1; m_x = 0; m_y = 0;
                end else if (m_y + 1 == TB_V) begin
                    e_fe = 1; m_locked = 0;
                end else begin
                    m_y = m_y + 1; m_x = 0; e_ls = 1; e_valid = 1;
                end
            end else if (de) begin
                e_valid = 1;
                if (m_high == TB_H) e_lle = 1;
                if (m_x < TB_H - 1) m_x = m_x + 1;
            end else if (f) begin
                e_lle = (m_high != TB_H);
            end
            if (r) begin
                m_low = 0; m_high = 1;
            end else if (de) begin
                if (m_high < 1023) m_high = m_high + 1;
            end else if (m_low < 1023) begin
                m_low = m_low + 1;
            end
            m_prev = de;
        end
        exp_v = {e_valid, 10'(m_x), 9'(m_y), e_ls, e_fs, m_locked, e_lle, e_fe};
    endfunction

    // Called at posedge+1: apply DE, step one clock, sample just after the edge.
    task automatic drive(input bit de);
        DE_in = de;
        @(posedge Clk);
        model_step(de, de_en);
        #1;
        cnt_valid += int'(pixel_valid);
        cnt_ls    += int'(line_start);
        cnt_fs    += int'(frame_start);
        cnt_lle   += int'(line_len_err);
        cnt_fe    += int'(frame_err);
        cnt_fefs  += int'(frame_err & frame_start);
        if (pixel_valid && int'(pixel_x) > max_x) max_x = int'(pixel_x);
        if (pixel_valid && int'(pixel_y) > max_y) max_y = int'(pixel_y);
        if (line_start)  last_ls_y = int'(pixel_y);
        if (frame_start) last_fs_y = int'(pixel_y);
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if (obs_v !== 25'd0) begin errors++; $display("FAIL reset_outs got=%h want=0", obs_v); end
        @(posedge Clk); #1;
        Rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL reset_idle i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
    endtask

    task automatic test_nominal();
        de_en = 1;
        clear_tally();
        seq.delete();
        add_run(0, 600);
        for (int f = 0; f < 2; f++)
            for (int l = 0; l < TB_V; l++) begin
                add_run(1, TB_H);
                add_run(0, (l == TB_V - 1) ? 600 : 47);
            end
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL nominal i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        checks++; if (cnt_fs !== 2) begin errors++; $display("FAIL nom_frame_starts got=%0d want=2", cnt_fs); end
        checks++; if (cnt_ls !== 2 * TB_V) begin errors++; $display("FAIL nom_line_starts got=%0d want=%0d", cnt_ls, 2 * TB_V); end
        checks++; if (cnt_lle + cnt_fe !== 0) begin errors++; $display("FAIL nom_errors got=%0d want=0", cnt_lle + cnt_fe); end
        checks++; if (max_x !== 478) begin errors++; $display("FAIL nom_last_x got=%0d want=478", max_x); end
        checks++; if (max_y !== TB_V - 1) begin errors++; $display("FAIL nom_last_y got=%0d want=%0d", max_y, TB_V - 1); end
        checks++; if (cnt_valid !== 2 * TB_V * TB_H) begin errors++; $display("FAIL nom_valid got=%0d want=%0d", cnt_valid, 2 * TB_V * TB_H); end
    endtask

    task automatic test_prelock();
        de_en = 0;
        for (int i = 0; i < 2; i++) begin
            drive(0); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL pre_clear i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        de_en = 1;
        clear_tally();
        seq.delete();
        add_run(0, 10);
        for (int l = 0; l < 4; l++) begin add_run(1, TB_H); add_run(0, 47); end
        add_run(1, TB_H); add_run(0, TB_VB - 1);
        add_run(1, TB_H); add_run(0, TB_VB);
        add_run(1, TB_H); add_run(0, 47);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL prelock i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        checks++; if (cnt_valid !== TB_H) begin errors++; $display("FAIL pre_valid got=%0d want=%0d", cnt_valid, TB_H); end
        checks++; if (cnt_fs !== 1) begin errors++; $display("FAIL pre_fs got=%0d want=1", cnt_fs); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_locked got=%b want=1", locked); end
    endtask

    task automatic test_short_line();
        clear_tally();
        seq.delete();
        add_run(1, 300); add_run(0, 47);
        add_run(1, TB_H); add_run(0, 47);
        add_run(1, TB_H + 6); add_run(0, 47);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL shortline i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        // one pulse for the short line, two for the long one (overrun and fall)
        checks++; if (cnt_lle !== 3) begin errors++; $display("FAIL sl_lle got=%0d want=3", cnt_lle); end
        checks++; if (last_ls_y !== 3) begin errors++; $display("FAIL sl_row got=%0d want=3", last_ls_y); end
        checks++; if (max_x !== 478) begin errors++; $display("FAIL sl_max_x got=%0d want=478", max_x); end
    endtask

    task automatic test_overflow();
        clear_tally();
        seq.delete();
        add_run(0, 600);
        for (int l = 0; l < TB_V + 3; l++) begin add_run(1, TB_H); add_run(0, 47); end
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL overflow i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        // first frame_err closes the 4-line frame left by the previous test
        checks++; if (cnt_fe !== 2) begin errors++; $display("FAIL ov_fe got=%0d want=2", cnt_fe); end
        checks++; if (cnt_valid !== TB_V * TB_H) begin errors++; $display("FAIL ov_valid got=%0d want=%0d", cnt_valid, TB_V * TB_H); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ov_locked got=%b want=0", locked); end
        checks++; if (dut.state_q !== SEEK) begin errors++; $display("FAIL ov_state got=%0d want=%0d", dut.state_q, SEEK); end
    endtask

    task automatic test_short_frame();
        clear_tally();
        seq.delete();
        add_run(0, 600);
        for (int l = 0; l < 10; l++) begin add_run(1, TB_H); add_run(0, (l == 9) ? 600 : 47); end
        add_run(1, TB_H); add_run(0, 47);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL shortframe i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        checks++; if (cnt_fe !== 1) begin errors++; $display("FAIL sf_fe got=%0d want=1", cnt_fe); end
        checks++; if (cnt_fefs !== 1) begin errors++; $display("FAIL sf_fe_with_fs got=%0d want=1", cnt_fefs); end
        checks++; if (last_fs_y !== 0) begin errors++; $display("FAIL sf_row got=%0d want=0", last_fs_y); end
    endtask

    task automatic test_disable();
        clear_tally();
        seq.delete();
        add_run(0, 600); add_run(1, 101);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL dis_pre i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        checks++; if (pixel_x !== 10'd100) begin errors++; $display("FAIL dis_x got=%0d want=100", pixel_x); end
        de_en = 0;
        drive(1); checks++;
        if (obs_v !== 25'd0) begin errors++; $display("FAIL dis_clear got=%h want=0", obs_v); end
        de_en = 1;
        seq.delete(); add_run(1, 20); add_run(0, 600);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL dis_blank i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        de_en = 0;
        drive(1); checks++;
        if (obs_v !== 25'd0) begin errors++; $display("FAIL dis_rise_clash got=%h want=0", obs_v); end
        de_en = 1;
        clear_tally();
        seq.delete();
        add_run(1, 478); add_run(0, 47); add_run(1, TB_H); add_run(0, TB_VB); add_run(1, TB_H); add_run(0, 47);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL dis_relock i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        checks++; if (cnt_fs !== 1 || cnt_valid !== TB_H) begin errors++; $display("FAIL dis_relock_cnt fs=%0d valid=%0d want 1/%0d", cnt_fs, cnt_valid, TB_H); end
    endtask

    task automatic test_async_reset();
        seq.delete(); add_run(0, 600); add_run(1, 50);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL ar_pre i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        #3 Rst_n = 0;
        #1; checks++;
        if (obs_v !== 25'd0) begin errors++; $display("FAIL ar_clear got=%h want=0", obs_v); end
        model_reset();
        @(posedge Clk); #1;
        Rst_n = 1;
        clear_tally();
        seq.delete();
        add_run(1, 429); add_run(0, 47); add_run(1, TB_H); add_run(0, 600); add_run(1, TB_H); add_run(0, 47);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL ar_post i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        checks++; if (cnt_fs !== 1 || cnt_valid !== TB_H) begin errors++; $display("FAIL ar_relock fs=%0d valid=%0d want 1/%0d", cnt_fs, cnt_valid, TB_H); end
    endtask

    task automatic test_random();
        int hl, ll, k;
        clear_tally();
        seq.delete(); add_run(0, 1100); add_run(1, TB_H); add_run(0, 40);
        foreach (seq[i]) begin
            drive(seq[i]); checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL rnd_sat i=%0d got=%h want=%h", i, obs_v, exp_v); end
        end
        checks++; if (cnt_fs !== 1) begin errors++; $display("FAIL rnd_sat_lock got=%0d want=1", cnt_fs); end
        for (int n = 0; n < 30; n++) begin
            hl = ($urandom_range(5, 0) == 0) ? int'($urandom_range(490, 1)) : TB_H;
            ll = ($urandom_range(7, 0) == 0) ? int'($urandom_range(1100, TB_VB)) : int'($urandom_range(60, 1));
            seq.delete(); add_run(1, hl); add_run(0, ll);
            foreach (seq[i]) begin
                drive(seq[i]); checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL rnd_line n=%0d i=%0d got=%h want=%h", n, i, obs_v, exp_v); end
            end
            if ($urandom_range(24, 0) == 0) begin
                k = int'($urandom_range(3, 1));
                de_en = 0;
                for (int j = 0; j < k; j++) begin
                    drive(0); checks++;
                    if (obs_v !== exp_v) begin errors++; $display("FAIL rnd_dis n=%0d got=%h want=%h", n, obs_v, exp_v); end
                end
                de_en = 1;
            end
        end
    endtask

    initial begin
        Clk = 0; Rst_n = 0; de_en = 0; DE_in = 0;
        checks = 0; errors = 0;
        clear_tally();
        test_reset();
        test_nominal();
        test_prelock();
        test_short_line();
        test_overflow();
        test_short_frame();
        test_disable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
